// File: rtl/shake_absorb_loader.sv
// shake_absorb_loader: absorb-side front end for the SHAKE core.
// Takes a header beat and W-bit message words, then builds rate-sized
// blocks with SHAKE padding and hands each block to the permutation stage.
// Optional feature macro: SHAKE_LOADER_BLKCNT_EN adds block_count_o.
module shake_absorb_loader #(
    parameter int unsigned W          = 64,
    parameter int unsigned LEN_W      = 32,
    parameter int unsigned RATE_MAX_W = 1344 / W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [W-1:0]     data_i,
    output logic             ready_o,
    output logic [1343:0]    block_o,
    output logic             block_valid_o,
    output logic             block_last_o,
    output logic             block_rate_o,
`ifdef SHAKE_LOADER_BLKCNT_EN
    output logic [15:0]      block_count_o,
`endif
    input  logic             block_ready_i
);

    localparam int unsigned BLK_W  = 1344;
    localparam int unsigned B      = W / 8;
    localparam int unsigned R128   = 1344 / W;
    localparam int unsigned R256   = 1088 / W;
    localparam int unsigned WIDX_W = $clog2(RATE_MAX_W + 1);
    localparam int unsigned PTR_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FILL    = 2'd1,
        S_PAD     = 2'd2,
        S_HANDOFF = 2'd3
    } state_e;

    state_e              state_q;
    logic [BLK_W-1:0]    buf_q;
    logic [LEN_W-1:0]    rem_q;
    logic [WIDX_W-1:0]   widx_q;
    logic [PTR_W-1:0]    ptr_q;
    logic                rate_q;
    logic                last_q;
    logic                valid_q;
`ifdef SHAKE_LOADER_BLKCNT_EN
    logic [15:0]         cnt_q;
`endif

    logic                accept;
    logic                part;
    logic                fin;
    logic                blk_end;
    logic [W-1:0]        word_m;
    logic [BLK_W-1:0]    word_vec;
    logic [BLK_W-1:0]    pad_vec;
    logic [LEN_W-1:0]    hdr_len;

    // Input handshake is decoded from state; forced low while in reset.
    assign ready_o = !rst && (state_q == S_IDLE || state_q == S_FILL);
    assign accept  = valid_i && ready_o;
    assign hdr_len = data_i[LEN_W-1:0];

    assign block_o       = buf_q;
    assign block_valid_o = valid_q;
    assign block_last_o  = last_q;
    assign block_rate_o  = rate_q;
`ifdef SHAKE_LOADER_BLKCNT_EN
    assign block_count_o = cnt_q;
`endif

    // Word masking, block placement and the padding pattern.
    always_comb begin
        part    = rem_q < LEN_W'(B);
        fin     = rem_q <= LEN_W'(B);
        blk_end = (widx_q == (rate_q ? WIDX_W'(R256 - 1) : WIDX_W'(R128 - 1)));
        word_m  = data_i;
        for (int b = 0; b < int'(B); b++) begin
            if (part && (LEN_W'(b) >= rem_q)) begin
                word_m[8*b +: 8] = 8'h00;
            end
        end
        word_vec = BLK_W'(word_m) << (int'(widx_q) * int'(W));
        pad_vec  = (BLK_W'(8'h1F) << (int'(ptr_q) * 8))
                 ^ (rate_q ? (BLK_W'(8'h80) << ((R256 * B - 1) * 8))
                           : (BLK_W'(8'h80) << ((R128 * B - 1) * 8)));
    end

    // Loader FSM with all block-side outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            rem_q   <= '0;
            widx_q  <= '0;
            ptr_q   <= '0;
            rate_q  <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef SHAKE_LOADER_BLKCNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        buf_q   <= '0;
                        widx_q  <= '0;
                        ptr_q   <= '0;
                        rem_q   <= hdr_len;
                        rate_q  <= data_i[W-1];
                        last_q  <= 1'b0;
`ifdef SHAKE_LOADER_BLKCNT_EN
                        cnt_q   <= '0;
`endif
                        state_q <= (hdr_len == '0) ? S_PAD : S_FILL;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        buf_q  <= buf_q | word_vec;
                        widx_q <= widx_q + WIDX_W'(1);
                        rem_q  <= fin ? '0 : (rem_q - LEN_W'(B));
                        // A partial final word always leaves room for padding here.
                        if (part) begin
                            ptr_q   <= PTR_W'(widx_q) * PTR_W'(B) + PTR_W'(rem_q);
                            state_q <= S_PAD;
                        end else if (blk_end) begin
                            last_q  <= 1'b0;
                            valid_q <= 1'b1;
                            state_q <= S_HANDOFF;
                        end else if (fin) begin
                            ptr_q   <= (PTR_W'(widx_q) + PTR_W'(1)) * PTR_W'(B);
                            state_q <= S_PAD;
                        end
                    end
                end
                S_PAD: begin
                    buf_q   <= buf_q ^ pad_vec;
                    last_q  <= 1'b1;
                    valid_q <= 1'b1;
                    state_q <= S_HANDOFF;
                end
                S_HANDOFF: begin
                    if (block_ready_i) begin
                        buf_q   <= '0;
                        widx_q  <= '0;
                        valid_q <= 1'b0;
`ifdef SHAKE_LOADER_BLKCNT_EN
                        if (cnt_q != 16'hFFFF) begin
                            cnt_q <= cnt_q + 16'd1;
                        end
`endif
                        if (last_q) begin
                            last_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else if (rem_q == '0) begin
                            // Message ended exactly on a block boundary.
                            ptr_q   <= '0;
                            state_q <= S_PAD;
                        end else begin
                            state_q <= S_FILL;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/shake_absorb_loader.md
# shake_absorb_loader

Parametrised absorb-side front end for the SHAKE core. It accepts a per-message header and a stream of `W`-bit message words over a valid/ready handshake, assembles them into rate-sized blocks and applies SHAKE padding in hardware. It also handles partial final words and the extra padding-only block. Each completed block is handed to the permutation stage over a valid/ready interface with a last-block flag. It sits between the host input port and the Keccak absorb/permute stage.

## Interface
Clock `clk`; reset `rst` is synchronous, active-high.

**Parameters**
- `W`, default 64: input word width. Legal values are 32 and 64.
- `LEN_W`, default 32: width of the message length in bytes. Must satisfy `LEN_W <= W-1`.
- `RATE_MAX_W`, default 1344/`W`: number of words in the largest rate (SHAKE128).

**Ports**
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous active-high reset.
- `valid_i`, in, 1: input beat valid.
- `data_i`, in, `W`: header beat or message word.
- `ready_o`, out, 1: input beat accepted when `valid_i && ready_o`.
- `block_o`, out, 1344: assembled block.
  - Byte k is at bits `[8k+:8]`.
  - Bytes at and above the active rate are 0.
- `block_valid_o`, out, 1: `block_o` holds a complete block.
- `block_last_o`, out, 1: the current block is the message's final padded block.
- `block_rate_o`, out, 1: 0 = SHAKE128 (168 B), 1 = SHAKE256 (136 B).
- `block_ready_i`, in, 1: consumer accepts the block.

## Operation
- **Header beat** (first beat of each message):
  - `data_i[LEN_W-1:0]` is `len` in bytes.
  - `data_i[W-1]` is the mode.
  - Mode and rate are latched at the header. Rate words R = 1344/`W` or 1088/`W`. B = `W`/8 bytes per word.
- **Data beats:** the message takes ceil(`len`/B) data beats, little-endian within each word.
  - Register `rem` counts the remaining message bytes.
  - Register `widx` counts words written into the current block.
  - On the final word, bytes at or above position `rem` are masked to 0.
- **Padding:** applied only in PAD.
  - Pointer p is the block byte index immediately after the last message byte.
  - PAD XORs 0x1F into byte p and 0x80 into byte R·B−1.
  - When p = R·B−1, the result is 0x9F.
- **States:**
  - IDLE
    - `ready_o`=1.
    - On a header beat: clear the buffer. Go to PAD if `len`=0, otherwise go to FILL.
  - FILL
    - `ready_o`=1.
    - Each accepted beat writes word `widx`, increments `widx` and decrements `rem` by min(B, `rem`).
    - When the accepted word fills the block (`widx`=R−1), go to HANDOFF with last=0.
    - Otherwise, when `rem` reaches 0 on this beat, go to PAD.
    - If both conditions hold on the same beat, the block-full rule wins. The pad-only block follows.
  - PAD
    - One cycle. `ready_o`=0.
    - Applies the padding bytes, then goes to HANDOFF with last=1.
  - HANDOFF
    - `block_valid_o`=1 and `ready_o`=0.
    - `block_o`, `block_last_o` and `block_rate_o` are held stable.
    - On `block_ready_i`: clear the buffer and `widx`, then:
      - if last, go to IDLE;
      - else if `rem`=0, go to PAD (message ended exactly on a block boundary);
      - else go to FILL.
- The buffer is single: no input beats are accepted while a block is pending.

## Timing
- **Reset:** in the cycle after `rst` is sampled high:
  - state is IDLE;
  - the buffer, `rem` and `widx` are 0;
  - `ready_o`, `block_valid_o`, `block_last_o` and `block_rate_o` are 0.
- **While `rst` is high:** `ready_o` is forced to 0.
- **Reset mid-operation:** abandons the message with no partial block emitted.
- **Header to data:** header accepted at cycle 0; the first data beat is accepted at cycle 1 at the earliest.
- **Full block:** with `valid_i` held high, R beats are accepted on consecutive cycles. `block_valid_o` rises in the cycle after the R-th accept.
- **Partial final block:** PAD adds exactly one cycle. `block_valid_o` rises 2 cycles after the final accept.
- **Handoff to next block:** the handshake completes in the cycle with `block_valid_o && block_ready_i`. `ready_o` (FILL) or PAD is active in the next cycle. There is no bubble beyond that.
- **Stability:** all outputs except `ready_o` are registered. `ready_o` is decoded from state. `block_o` changes only in FILL, PAD or on clear.

## Configuration
- `SHAKE_LOADER_BLKCNT_EN` defined:
  - Adds output `block_count_o` [15:0], the count of blocks handed off in the current message.
  - Cleared on header accept and incremented on each handoff.
  - Saturates at 0xFFFF. Resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- **Empty message:** `W`=64, SHAKE128, `len`=0, no data beats → one block with byte0=0x1F, byte167=0x80, all other bytes 0, last=1, rate=0.
- **Length exactly one rate:** SHAKE256, `len`=136, 17 beats of an incrementing byte pattern.
  - Block 1: bytes 0..135 = pattern, last=0.
  - Block 2: byte0=0x1F, byte135=0x80, bytes 1..134 and 136..167 = 0, last=1.
- **Pad bytes collide:** SHAKE128, `len`=167, 21 beats of 0x00 → single block with byte167=0x9F, last=1.
- **Partial final word masking:** SHAKE256, `len`=10, 2 beats of all-ones → bytes 0..9=0xFF, byte10=0x1F, bytes 11..134=0, byte135=0x80.
- **Consumer backpressure:** `block_ready_i` held low for 5 cycles during HANDOFF → `block_o` is constant, `ready_o`=0 and no beat is accepted. When released, FILL resumes on the next cycle.
- **Reset mid-FILL:** reset after 5 of 21 beats → the next cycle is IDLE with all outputs 0 and no block emitted. A following `len`=0 header produces a correct single pad block. With `SHAKE_LOADER_BLKCNT_EN`, `block_count_o`=1 after that handoff.
